// File: rtl/peak_lock_ctrl_pkg.sv
// Shared types and default constants for the peak lock controller.
// Optional macro used by this slice: PEAK_TOL_EN (see bin_match).
package peak_lock_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_SEARCH = 3'd3,
        ST_EVAL   = 3'd4
    } state_t;

    localparam int DEF_DATA_WIDTH      = 16;
    localparam int DEF_BOUND_NUM       = 32;
    localparam int DEF_BOUND_NUM_WIDTH = 5;
    localparam int DEF_WIN_LEN         = 4096;
    localparam int DEF_LOCK_CNT        = 4;
    localparam int DEF_SEARCH_TO       = 64;

    // Bits needed for a counter that runs 0 .. n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/peak_lock_ctrl_if.sv
// Handshake/bus between the lock controller (master) and the histogram accumulator (slave).
interface peak_lock_ctrl_if
    import peak_lock_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int BOUND_NUM       = DEF_BOUND_NUM,
    parameter int BOUND_NUM_WIDTH = DEF_BOUND_NUM_WIDTH
);
    logic                            clear_o;
    logic                            start_search_o;
    logic                            stat_val_i;
    logic [BOUND_NUM_WIDTH-1:0]      max_num_i;
    logic [DATA_WIDTH*BOUND_NUM-1:0] arr_i;

    modport master (
        output clear_o,
        output start_search_o,
        input  stat_val_i,
        input  max_num_i,
        input  arr_i
    );

    modport slave (
        input  clear_o,
        input  start_search_o,
        output stat_val_i,
        output max_num_i,
        output arr_i
    );
endinterface

// File: rtl/peak_lock_ctrl_bin_match.sv
// Combinational match of the current peak bin against the previous one.
// With PEAK_TOL_EN defined, neighbouring bins (circular, BOUND_NUM-1 next to 0) also match.
module bin_match
    import peak_lock_ctrl_pkg::*;
#(
    parameter int BOUND_NUM       = DEF_BOUND_NUM,
    parameter int BOUND_NUM_WIDTH = DEF_BOUND_NUM_WIDTH
) (
    input  logic [BOUND_NUM_WIDTH-1:0] cur_i,
    input  logic [BOUND_NUM_WIDTH-1:0] prev_i,
    output logic                       match_o
);

`ifdef PEAK_TOL_EN
    logic [BOUND_NUM_WIDTH-1:0] prev_up;
    logic [BOUND_NUM_WIDTH-1:0] prev_dn;

    always_comb begin
        prev_up = (prev_i == BOUND_NUM_WIDTH'(BOUND_NUM - 1)) ? '0 : prev_i + 1'b1;
        prev_dn = (prev_i == '0) ? BOUND_NUM_WIDTH'(BOUND_NUM - 1) : prev_i - 1'b1;
        match_o = (cur_i == prev_i) || (cur_i == prev_up) || (cur_i == prev_dn);
    end
`else
    assign match_o = (cur_i == prev_i);
`endif

endmodule

// File: rtl/peak_lock_ctrl.sv
// Windowed histogram peak tracker: clears, accumulates, requests max-search, and locks on a stable peak.
// Optional macro PEAK_TOL_EN widens the bin match to +/-1 (circular).
module peak_lock_ctrl
    import peak_lock_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int BOUND_NUM       = DEF_BOUND_NUM,
    parameter int BOUND_NUM_WIDTH = DEF_BOUND_NUM_WIDTH,
    parameter int WIN_LEN         = DEF_WIN_LEN,
    parameter int LOCK_CNT        = DEF_LOCK_CNT,
    parameter int SEARCH_TO       = DEF_SEARCH_TO
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable_i,
    input  logic                       sample_val_i,
    input  logic [DATA_WIDTH-1:0]      thresh_i,
    peak_lock_ctrl_if.master           acc_if,
    output logic [BOUND_NUM_WIDTH-1:0] bin_o,
    output logic [DATA_WIDTH-1:0]      peak_o,
    output logic                       bin_val_o,
    output logic                       lock_o,
    output logic                       timeout_o
);

    localparam int SAMP_W   = cnt_width(WIN_LEN);
    localparam int WAIT_W   = cnt_width(SEARCH_TO);
    localparam int STREAK_W = $clog2(LOCK_CNT + 1);

    state_t                     state_q, state_d;
    logic [SAMP_W-1:0]          samp_cnt_q, samp_cnt_d;
    logic [WAIT_W-1:0]          wait_cnt_q, wait_cnt_d;
    logic [STREAK_W-1:0]        streak_q, streak_d;
    logic [BOUND_NUM_WIDTH-1:0] bin_q, bin_d;
    logic [DATA_WIDTH-1:0]      peak_q, peak_d;
    logic                       bin_val_q, bin_val_d;
    logic                       lock_q, lock_d;
    logic                       timeout_q, timeout_d;

    logic [DATA_WIDTH-1:0]      bins_w [BOUND_NUM];
    logic [DATA_WIDTH-1:0]      cur_peak_w;
    logic                       match_w;
    logic [STREAK_W-1:0]        eval_streak_w;

    generate
        for (genvar gi = 0; gi < BOUND_NUM; gi++) begin : g_bins
            assign bins_w[gi] = acc_if.arr_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign cur_peak_w = bins_w[acc_if.max_num_i];

    // bin_q doubles as the previous evaluated bin for the streak rule.
    bin_match #(
        .BOUND_NUM       (BOUND_NUM),
        .BOUND_NUM_WIDTH (BOUND_NUM_WIDTH)
    ) u_bin_match (
        .cur_i   (acc_if.max_num_i),
        .prev_i  (bin_q),
        .match_o (match_w)
    );

    always_comb begin
        eval_streak_w = STREAK_W'(1);
        if (cur_peak_w < thresh_i) begin
            eval_streak_w = '0;
        end else if ((streak_q != '0) && match_w) begin
            eval_streak_w = (streak_q == STREAK_W'(LOCK_CNT)) ? streak_q : streak_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        samp_cnt_d = samp_cnt_q;
        wait_cnt_d = wait_cnt_q;
        streak_d   = streak_q;
        bin_d      = bin_q;
        peak_d     = peak_q;
        bin_val_d  = 1'b0;
        lock_d     = lock_q;
        timeout_d  = 1'b0;

        if (!enable_i) begin
            // Disable acts as a soft restart: everything returns to its reset value.
            state_d    = ST_IDLE;
            samp_cnt_d = '0;
            wait_cnt_d = '0;
            streak_d   = '0;
            bin_d      = '0;
            peak_d     = '0;
            lock_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_CLEAR;
                end
                ST_CLEAR: begin
                    samp_cnt_d = '0;
                    state_d    = ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (sample_val_i) begin
                        if (samp_cnt_q == SAMP_W'(WIN_LEN - 1)) begin
                            wait_cnt_d = '0;
                            state_d    = ST_SEARCH;
                        end else begin
                            samp_cnt_d = samp_cnt_q + 1'b1;
                        end
                    end
                end
                ST_SEARCH: begin
                    if (acc_if.stat_val_i) begin
                        state_d = ST_EVAL;
                    end else if (wait_cnt_q == WAIT_W'(SEARCH_TO - 1)) begin
                        timeout_d = 1'b1;
                        streak_d  = '0;
                        lock_d    = 1'b0;
                        state_d   = ST_CLEAR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
                ST_EVAL: begin
                    bin_d     = acc_if.max_num_i;
                    peak_d    = cur_peak_w;
                    bin_val_d = 1'b1;
                    streak_d  = eval_streak_w;
                    lock_d    = (eval_streak_w == STREAK_W'(LOCK_CNT));
                    state_d   = ST_CLEAR;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            samp_cnt_q <= '0;
            wait_cnt_q <= '0;
            streak_q   <= '0;
            bin_q      <= '0;
            peak_q     <= '0;
            bin_val_q  <= 1'b0;
            lock_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            samp_cnt_q <= samp_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            streak_q   <= streak_d;
            bin_q      <= bin_d;
            peak_q     <= peak_d;
            bin_val_q  <= bin_val_d;
            lock_q     <= lock_d;
            timeout_q  <= timeout_d;
        end
    end

    // Strobes decode straight from the state register, so they are mutually exclusive.
    assign acc_if.clear_o        = (state_q == ST_CLEAR);
    assign acc_if.start_search_o = (state_q == ST_SEARCH);

    assign bin_o     = bin_q;
    assign peak_o    = peak_q;
    assign bin_val_o = bin_val_q;
    assign lock_o    = lock_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_peak_lock_ctrl.sv
// Randomised bench for peak_lock_ctrl with a window-level reference model and directed literal checks.
module tb_peak_lock_ctrl;

    localparam int DW   = 16;
    localparam int BN   = 32;
    localparam int BW   = 5;
    localparam int WIN  = 16;
    localparam int LOCK = 4;
    localparam int STO  = 64;
`ifdef PEAK_TOL_EN
    localparam bit TOL = 1'b1;
`else
    localparam bit TOL = 1'b0;
`endif

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b0;
    logic          enable     = 1'b0;
    logic          sample_val = 1'b0;
    logic [DW-1:0] thresh     = '0;
    logic [BW-1:0] bin_o;
    logic [DW-1:0] peak_o;
    logic          bin_val_o, lock_o, timeout_o;
    logic [DW-1:0] bins_tb [BN];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    peak_lock_ctrl_if #(.DATA_WIDTH(DW), .BOUND_NUM(BN), .BOUND_NUM_WIDTH(BW)) acc_if ();

    peak_lock_ctrl #(
        .DATA_WIDTH(DW), .BOUND_NUM(BN), .BOUND_NUM_WIDTH(BW),
        .WIN_LEN(WIN), .LOCK_CNT(LOCK), .SEARCH_TO(STO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable_i     (enable),
        .sample_val_i (sample_val),
        .thresh_i     (thresh),
        .acc_if       (acc_if),
        .bin_o        (bin_o),
        .peak_o       (peak_o),
        .bin_val_o    (bin_val_o),
        .lock_o       (lock_o),
        .timeout_o    (timeout_o)
    );

    generate
        for (genvar gi = 0; gi < BN; gi++) begin : g_pack
            assign acc_if.arr_i[gi*DW +: DW] = bins_tb[gi];
        end
    endgenerate

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, act=running req=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase: 0 idle, 1 clear, 2 accumulate, 3 wait for search result, 4 evaluate.
    int            m_phase, m_got, m_waited, m_streak;
    logic [BW-1:0] m_bin;
    logic [DW-1:0] m_peak;
    logic          m_binval, m_lock, m_timeout;

    function automatic bit near(input int a, input int b);
        int d;
        d = (a - b + BN) % BN;
        return (d == 0) || (TOL && (d == 1 || d == BN - 1));
    endfunction

    function automatic int next_streak(input int s, input int pk, input int th, input bit nr);
        if (pk < th) return 0;
        if (s > 0 && nr) return (s + 1 > LOCK) ? LOCK : s + 1;
        return 1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n || !enable) begin
            m_phase <= 0; m_got <= 0; m_waited <= 0; m_streak <= 0;
            m_bin <= '0; m_peak <= '0; m_binval <= 1'b0; m_lock <= 1'b0; m_timeout <= 1'b0;
        end else begin
            m_binval  <= 1'b0;
            m_timeout <= 1'b0;
            case (m_phase)
                0: m_phase <= 1;
                1: begin m_phase <= 2; m_got <= 0; end
                2: if (sample_val) begin
                       if (m_got + 1 == WIN) begin m_phase <= 3; m_waited <= 0; end
                       else m_got <= m_got + 1;
                   end
                3: if (acc_if.stat_val_i) m_phase <= 4;
                   else if (m_waited + 1 == STO) begin
                       m_phase <= 1; m_timeout <= 1'b1; m_streak <= 0; m_lock <= 1'b0;
                   end else m_waited <= m_waited + 1;
                default: begin
                    m_phase  <= 1;
                    m_bin    <= acc_if.max_num_i;
                    m_peak   <= bins_tb[acc_if.max_num_i];
                    m_binval <= 1'b1;
                    m_streak <= next_streak(m_streak, int'(bins_tb[acc_if.max_num_i]), int'(thresh),
                                            near(int'(acc_if.max_num_i), int'(m_bin)));
                    m_lock   <= (next_streak(m_streak, int'(bins_tb[acc_if.max_num_i]), int'(thresh),
                                             near(int'(acc_if.max_num_i), int'(m_bin))) == LOCK);
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("clear_o",        32'(acc_if.clear_o),        32'(m_phase == 1));
            check("start_search_o", 32'(acc_if.start_search_o), 32'(m_phase == 3));
            check("bin_o",          32'(bin_o),                 32'(m_bin));
            check("peak_o",         32'(peak_o),                32'(m_peak));
            check("bin_val_o",      32'(bin_val_o),             32'(m_binval));
            check("lock_o",         32'(lock_o),                32'(m_lock));
            check("timeout_o",      32'(timeout_o),             32'(m_timeout));
            check("strobe_excl",    32'(acc_if.clear_o & acc_if.start_search_o), 32'(0));
        end
    end

    // ---------------- stimulus ----------------
    int  resp_delay = 3;
    bit  noresp     = 1'b0;
    int  samp_pct   = 100;
    int  n_clear = 0, n_binval = 0, ss_cnt = 0, since_clear = 0;
    int  clr_to_ss = 0, last_ss = 0, last_clr = 0;

    // One clock: observe DUT just after the edge, then drive the next cycle's inputs.
    task automatic step();
        @(posedge clk);
        #1;
        since_clear++;
        if (bin_val_o || timeout_o) begin last_ss = ss_cnt; last_clr = n_clear; end
        if (bin_val_o) n_binval++;
        if (acc_if.clear_o) begin n_clear++; ss_cnt = 0; since_clear = 0; end
        if (acc_if.start_search_o) begin
            ss_cnt++;
            if (ss_cnt == 1) clr_to_ss = since_clear;
        end
        acc_if.stat_val_i = acc_if.start_search_o && !noresp && (ss_cnt >= resp_delay);
        sample_val = acc_if.clear_o ? 1'b1 : ($urandom_range(99) < samp_pct);
    endtask

    // sel: 0 = bin_val_o, 1 = timeout_o, 2 = start_search_o
    task automatic wait_ev(input int sel, input int bound, input string what);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            step();
            seen = (sel == 0) ? bin_val_o : (sel == 1) ? timeout_o : acc_if.start_search_o;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: event not seen, actual=timeout required=event within %0d cycles", what, bound);
        end
    endtask

    task automatic set_window(input int b, input int pk);
        for (int k = 0; k < BN; k++) bins_tb[k] = DW'($urandom);
        bins_tb[b] = DW'(pk);
        acc_if.max_num_i = BW'(b);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_clear"},  32'(acc_if.clear_o),        0);
        check({tag, "_search"}, 32'(acc_if.start_search_o), 0);
        check({tag, "_bin"},    32'(bin_o),     0);
        check({tag, "_peak"},   32'(peak_o),    0);
        check({tag, "_binval"}, 32'(bin_val_o), 0);
        check({tag, "_lock"},   32'(lock_o),    0);
        check({tag, "_tout"},   32'(timeout_o), 0);
    endtask

    int seq49 [4] = '{31, 0, 1, 0};
    int picks [6] = '{5, 6, 7, 31, 0, 1};

    initial begin
        acc_if.stat_val_i = 1'b0;
        set_window(0, 0);
        thresh = 16'd5;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk_zero("reset");
        reset_n = 1'b1;
        step(); step();
        chk_zero("idle_wait");

        // Single window: bin 7 count 12, search answered after 3 cycles.
        set_window(7, 12);
        n_clear = 0; n_binval = 0;
        enable = 1'b1;
        wait_ev(0, 200, "win1");
        check("w1_bin",         32'(bin_o),  7);
        check("w1_peak",        32'(peak_o), 12);
        check("w1_clears",      32'(last_clr), 1);
        check("w1_search_len",  32'(last_ss), 3);
        check("w1_accum_span",  32'(clr_to_ss), WIN + 1);
        check("w1_lock",        32'(lock_o), 0);
        step(); step();
        check("w1_binval_once", 32'(n_binval), 1);

        // Lock after the 4th matching window, drop on a new bin, relock after 3 more.
        for (int w = 2; w <= 4; w++) begin
            resp_delay = $urandom_range(1, 6);
            set_window(7, 12 + w);
            wait_ev(0, 200, "lockwin");
            check("lk_peak", 32'(peak_o), 32'(12 + w));
            check("lk_lock", 32'(lock_o), 32'(w == 4));
        end
        for (int w = 5; w <= 8; w++) begin
            set_window(12, 20);
            wait_ev(0, 200, "bin12win");
            check("b12_bin",  32'(bin_o), 12);
            check("b12_lock", 32'(lock_o), 32'(w == 8));
        end

        // Below-threshold peak still reports, but kills the streak.
        set_window(12, 4);
        wait_ev(0, 200, "lowpeak");
        check("low_peak", 32'(peak_o), 4);
        check("low_lock", 32'(lock_o), 0);
        set_window(12, 9);
        wait_ev(0, 200, "after_low");
        check("after_low_lock", 32'(lock_o), 0);

        // Circular neighbours: 31,0,1,0 locks only with tolerance.
        for (int w = 0; w < 4; w++) begin
            set_window(seq49[w], 12);
            wait_ev(0, 200, "wrapwin");
            check("wrap_lock", 32'(lock_o), (w == 3) ? 32'(TOL) : 32'(0));
        end

        // SEARCH timeout.
        noresp = 1'b1;
        set_window(3, 12);
        wait_ev(1, 400, "timeout");
        check("to_search_len", 32'(last_ss), STO);
        check("to_clear",      32'(acc_if.clear_o), 1);
        check("to_lock",       32'(lock_o), 0);
        noresp = 1'b0;
        step();
        check("to_accum_clear",  32'(acc_if.clear_o), 0);
        check("to_accum_search", 32'(acc_if.start_search_o), 0);
        wait_ev(0, 200, "after_to");

        // Asynchronous reset in the middle of accumulation.
        repeat (5) step();
        reset_n = 1'b0;
        #1;
        chk_zero("async_rst");
        step();
        reset_n = 1'b1;
        wait_ev(0, 200, "after_rst");
        check("rst_accum_span", 32'(clr_to_ss), WIN + 1);
        check("rst_lock",       32'(lock_o), 0);

        // Disable during SEARCH.
        noresp = 1'b1;
        wait_ev(2, 200, "reach_search");
        step(); step();
        enable = 1'b0;
        step();
        chk_zero("disable");
        noresp = 1'b0;
        enable = 1'b1;
        wait_ev(0, 200, "after_dis");
        check("dis_accum_span", 32'(clr_to_ss), WIN + 1);

        // Randomised windows; the model checks every cycle.
        for (int w = 0; w < 60; w++) begin
            thresh     = DW'($urandom_range(3, 8));
            resp_delay = $urandom_range(1, 8);
            samp_pct   = $urandom_range(30, 100);
            noresp     = ($urandom_range(9) == 0);
            set_window(picks[$urandom_range(5)], $urandom_range(2, 12));
            wait_ev(noresp ? 1 : 0, 600, "rand");
            noresp = 1'b0;
            if ($urandom_range(7) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 3)) step();
                enable = 1'b1;
            end
        end

        repeat (4) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/peak_lock_ctrl.md
PEAK_LOCK_CTRL -- requirements
Module: peak_lock_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of each histogram bin count and of the threshold.
REQ-002 Parameter BOUND_NUM, default 32: number of histogram bins; only 32 is supported.
REQ-003 Parameter BOUND_NUM_WIDTH, default 5: width of a bin index.
REQ-004 Parameter WIN_LEN, default 4096: valid samples per accumulation window.
REQ-005 Parameter LOCK_CNT, default 4: consecutive matching windows required for lock.
REQ-006 Parameter SEARCH_TO, default 64: SEARCH timeout, in cycles.
REQ-007 Port clk, input, 1: the single clock; all logic is rising-edge.
REQ-008 Port reset_n, input, 1: reset, asynchronous, active-low.
REQ-009 Port enable_i, input, 1: run the accumulation/evaluation cycle.
REQ-010 Port sample_val_i, input, 1: CORDIC sample valid, the same strobe that feeds the accumulator.
REQ-011 Port thresh_i, input, DATA_WIDTH: minimum peak count for a window to be valid.
REQ-012 Port stat_val_i, input, 1: accumulator max-search done.
REQ-013 Port max_num_i, input, BOUND_NUM_WIDTH: accumulator peak bin index.
REQ-014 Port arr_i, input, DATA_WIDTH*BOUND_NUM: packed histogram; bin k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-015 Port clear_o, output, 1: accumulator clear pulse.
REQ-016 Port start_search_o, output, 1: accumulator max-search request.
REQ-017 Port bin_o, output, BOUND_NUM_WIDTH: last evaluated peak bin.
REQ-018 Port peak_o, output, DATA_WIDTH: last evaluated peak count.
REQ-019 Port bin_val_o, output, 1: one-cycle pulse when bin_o and peak_o update.
REQ-020 Port lock_o, output, 1: stable peak detected.
REQ-021 Port timeout_o, output, 1: one-cycle pulse when SEARCH times out.

Function
REQ-022 The FSM SHALL have states IDLE, CLEAR, ACCUM, SEARCH and EVAL.
REQ-023 IDLE SHALL go to CLEAR on enable_i=1.
REQ-024 CLEAR SHALL last one cycle with clear_o=1, then go to ACCUM.
REQ-025 A sample_val_i asserted during CLEAR SHALL NOT be counted.
REQ-026 ACCUM SHALL count sample_val_i pulses; on the WIN_LEN-th pulse it SHALL go to SEARCH, and the counter SHALL be reset on entry to ACCUM.
REQ-027 SEARCH SHALL hold start_search_o=1 until stat_val_i=1 is sampled, then go to EVAL.
REQ-028 If stat_val_i stays 0 for SEARCH_TO cycles, SEARCH SHALL pulse timeout_o, clear the streak and go to CLEAR.
REQ-029 In EVAL (one cycle), peak_o SHALL be loaded with bin max_num_i of arr_i, bin_o with max_num_i, and bin_val_o SHALL pulse.
REQ-030 Streak rule: if peak < thresh_i, streak SHALL be set to 0.
REQ-031 Streak rule: else if streak > 0 and the bin matches the previous bin, streak SHALL increment, saturating at LOCK_CNT.
REQ-032 Streak rule: otherwise streak SHALL be set to 1.
REQ-033 lock_o SHALL be registered and equal to (streak == LOCK_CNT), updated in EVAL.
REQ-034 After EVAL the FSM SHALL go to CLEAR while enable_i=1, and to IDLE otherwise.
REQ-035 On enable_i=0 in any state, the FSM SHALL enter IDLE at the next edge, and streak and lock_o SHALL clear.
REQ-036 clear_o and start_search_o SHALL never be asserted together.
REQ-037 Latency SHALL be 1 cycle from stat_val_i sampled to bin_val_o.

Reset
REQ-038 On reset_n=0 the FSM SHALL go to IDLE asynchronously.
REQ-039 On reset_n=0 the counters, streak and previous bin SHALL reset to 0.
REQ-040 On reset_n=0 all outputs SHALL reset to 0: clear_o, start_search_o, bin_o, peak_o, bin_val_o, lock_o, timeout_o.
REQ-041 After reset release the FSM SHALL wait for enable_i=1 before leaving IDLE.

Configuration
REQ-042 Macro PEAK_TOL_EN defined: a bin SHALL also match the previous bin when they differ by one, modulo BOUND_NUM (31 and 0 are adjacent).
REQ-043 Macro PEAK_TOL_EN undefined: only an exactly equal bin SHALL match.

Structure
REQ-044 A shared package SHALL hold the FSM state typedef and the default constants (WIN_LEN, LOCK_CNT, SEARCH_TO).
REQ-045 Sub-module bin_match SHALL perform the combinational match of current and previous bin, including the PEAK_TOL_EN wrap logic.

Verification
REQ-046 Scenario: WIN_LEN=16, 16 valid samples, stat_val_i after 3 cycles, max_num_i=7, bin7=12, thresh_i=5 -> one clear_o pulse, start_search_o high 3 cycles, bin_o=7, peak_o=12, bin_val_o pulses once.
REQ-047 Scenario: four consecutive windows with peak bin 7, count above threshold -> lock_o rises after the 4th EVAL; a 5th window with bin 12 -> lock_o falls and streak=1.
REQ-048 Scenario: peak=4 with thresh_i=5 -> streak=0 and lock_o=0, while bin_val_o still pulses.
REQ-049 Scenario: with PEAK_TOL_EN, bins 31,0,1,0 -> lock_o=1; without the macro the same sequence -> lock_o=0.
REQ-050 Scenario: stat_val_i held at 0 in SEARCH -> timeout_o pulses at cycle 64, then clear_o pulses and the FSM is in ACCUM.
REQ-051 Scenario: reset_n low mid-ACCUM, or enable_i low mid-SEARCH -> all outputs 0 and IDLE; no sample counted until after the next CLEAR.
